crc_chan_scheduler: RTL

Two-channel scheduler that time-shares one bytewise CRC-32 update datapath between two independent byte-stream requesters. Each channel keeps its own running CRC context. A round-robin arbiter grants at most one byte per cycle. Final CRCs are returned on a shared result bus. It sits between peripheral register front-ends (or streaming sources) and the CRC arithmetic, replacing a single-context FIFO-fed engine.

---
 rtl/crc_sched_pkg.sv | 33 +++
 rtl/crc32_byte_step.sv | 22 ++
 rtl/crc_chan_scheduler.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/crc_sched_pkg.sv
// Shared types and constants for the two-channel CRC-32 scheduler.
// Optional feature macro: CRC_REFLECT_EN (enables bit reflection helpers' use).
package crc_sched_pkg;

   localparam int          NUM_CH             = 2;
   localparam logic [31:0] CRC32_POLY_DEFAULT = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT_ONES    = 32'hFFFFFFFF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      FINISH = 2'd2
   } ch_state_e;

   // Bit-reverse a byte (used for reflected-input CRC variants).
   function automatic logic [7:0] reflect8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = v[7-i];
      end
      return r;
   endfunction

   // Bit-reverse a 32-bit word (used for reflected-output CRC variants).
   function automatic logic [31:0] reflect32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// Combinational bytewise CRC-32 update, MSB-first, arbitrary polynomial.
module crc32_byte_step (
   input  logic [31:0] crc,
   input  logic [7:0]  data,
   input  logic [31:0] poly,
   output logic [31:0] crc_next
);

   // Eight serial shift/feedback iterations unrolled into one cycle.
   always_comb begin
      logic [31:0] c;
      logic        fb;
      c  = crc;
      fb = 1'b0;
      for (int i = 0; i < 8; i++) begin
         fb = c[31] ^ data[7-i];
         c  = {c[30:0], 1'b0} ^ (fb ? poly : 32'h0);
      end
      crc_next = c;
   end

endmodule

// File: rtl/crc_chan_scheduler.sv
// Two-channel scheduler sharing one CRC-32 byte-step datapath.
// Each channel keeps its own running context; a round-robin arbiter grants
// at most one byte per cycle. Optional macro CRC_REFLECT_EN adds the refin
// port and input/output bit reflection.
module crc_chan_scheduler
   import crc_sched_pkg::*;
#(
   parameter logic [31:0] XOR_VALUE = 32'hFFFFFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  ch_start,
   input  logic [1:0]  ch_valid,
   input  logic [1:0]  ch_last,
   input  logic [7:0]  ch_data0,
   input  logic [7:0]  ch_data1,
   output logic [1:0]  ch_ready,
   input  logic [31:0] poly,
   input  logic        init_ones,
   input  logic        xor_out,
`ifdef CRC_REFLECT_EN
   input  logic        refin,
`endif
   output logic [1:0]  ch_busy,
   output logic        res_valid,
   output logic        res_chan,
   output logic [31:0] res_data
);

   ch_state_e   state_q [NUM_CH];
   ch_state_e   state_d [NUM_CH];
   logic [31:0] ctx_q   [NUM_CH];
   logic [31:0] ctx_d   [NUM_CH];
   logic        ptr_q, ptr_d;
   logic        res_valid_q, res_valid_d;
   logic        res_chan_q, res_chan_d;
   logic [31:0] res_data_q, res_data_d;

   logic [1:0]  req;
   logic [1:0]  grant;
   logic        sel;
   logic [7:0]  step_data;
   logic [31:0] step_crc;
   logic [31:0] step_next;
   logic [31:0] init_val;
   logic        fin_sel;
   logic [31:0] fin_crc;

   // Requests: an active channel offering a byte and not restarting this cycle.
   always_comb begin
      req = 2'b00;
      for (int c = 0; c < NUM_CH; c++) begin
         req[c] = (state_q[c] == ACTIVE) && ch_valid[c] && !ch_start[c];
      end
   end

   // Round-robin grant; the pointer only breaks ties between two requesters.
   always_comb begin
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   // Shared datapath input mux driven by the grant.
   always_comb begin
      logic [7:0] raw;
      sel      = grant[1];
      raw      = sel ? ch_data1 : ch_data0;
`ifdef CRC_REFLECT_EN
      step_data = refin ? reflect8(raw) : raw;
`else
      step_data = raw;
`endif
      step_crc = ctx_q[sel];
      init_val = init_ones ? CRC32_INIT_ONES : 32'h0;
   end

   crc32_byte_step u_step (
      .crc      (step_crc),
      .data     (step_data),
      .poly     (poly),
      .crc_next (step_next)
   );

   // Per-channel FSM and context update.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         state_d[c] = state_q[c];
         ctx_d[c]   = ctx_q[c];
         case (state_q[c])
            IDLE: begin
               if (ch_start[c]) begin
                  state_d[c] = ACTIVE;
                  ctx_d[c]   = init_val;
               end
            end
            ACTIVE: begin
               if (ch_start[c]) begin
                  ctx_d[c] = init_val;
               end else if (grant[c]) begin
                  ctx_d[c] = step_next;
                  if (ch_last[c]) begin
                     state_d[c] = FINISH;
                  end
               end
            end
            FINISH: begin
               if (ch_start[c]) begin
                  state_d[c] = ACTIVE;
                  ctx_d[c]   = init_val;
               end else begin
                  state_d[c] = IDLE;
               end
            end
            default: state_d[c] = IDLE;
         endcase
      end
   end

   // Result formatting; at most one channel can be in FINISH at a time.
   always_comb begin
      logic [31:0] raw_fin;
      fin_sel = (state_q[1] == FINISH);
      raw_fin = ctx_q[fin_sel];
`ifdef CRC_REFLECT_EN
      fin_crc = refin ? reflect32(raw_fin) : raw_fin;
`else
      fin_crc = raw_fin;
`endif
      if (xor_out) begin
         fin_crc = fin_crc ^ XOR_VALUE;
      end
      res_valid_d = (state_q[0] == FINISH) || (state_q[1] == FINISH);
      res_chan_d  = res_valid_d ? fin_sel : res_chan_q;
      res_data_d  = res_valid_d ? fin_crc : res_data_q;
      ptr_d       = (grant != 2'b00) ? grant[0] : ptr_q;
   end

   // State and result registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c] <= IDLE;
            ctx_q[c]   <= 32'h0;
         end
         ptr_q       <= 1'b0;
         res_valid_q <= 1'b0;
         res_chan_q  <= 1'b0;
         res_data_q  <= 32'h0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c] <= state_d[c];
            ctx_q[c]   <= ctx_d[c];
         end
         ptr_q       <= ptr_d;
         res_valid_q <= res_valid_d;
         res_chan_q  <= res_chan_d;
         res_data_q  <= res_data_d;
      end
   end

   // Busy flags follow the registered channel states.
   always_comb begin
      ch_busy = 2'b00;
      for (int c = 0; c < NUM_CH; c++) begin
         ch_busy[c] = (state_q[c] != IDLE);
      end
   end

   assign ch_ready  = grant;
   assign res_valid = res_valid_q;
   assign res_chan  = res_chan_q;
   assign res_data  = res_data_q;

endmodule
